spi_txn_sequencer: RTL and testbench

SPI_TXN_SEQUENCER -- requirements
Module: spi_txn_sequencer

---
 rtl/spi_txn_sequencer.sv | 149 ++++++++++++++
 tb/tb_spi_txn_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_sequencer.sv
// SPI transaction sequencer: START, CMD, 10-bit word, optional read turnaround and RX byte.
// Optional SPI_SEQ_AUTOREAD_EN: an op 10 frame is followed by an automatic op 11 frame.
module spi_txn_sequencer #(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CMD,
    S_SHIFT,
    S_WAIT,
    S_RX,
    S_GAP
  } state_t;

  localparam logic [4:0] GAP_LAST = 5'(GAP - 1);
  localparam logic [4:0] RD_LAST  = 5'(RD_LAT - 1);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] shift_q, shift_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic [9:0] word_d;

  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    shift_d     = shift_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_START;
          op_d    = req_op;
          data_d  = req_data;
        end
      end
      S_START: state_d = S_CMD;
      S_CMD:   state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == 5'd9) begin
          if (op_q != 2'b11)
            state_d = S_GAP;
          else if (RD_LAT > 0)
            state_d = S_WAIT;
          else
            state_d = S_RX;
        end
      end
      S_WAIT: begin
        if (cnt_q == RD_LAST)
          state_d = S_RX;
      end
      S_RX: begin
        shift_d = {shift_q[6:0], MISO};
        if (cnt_q == 5'd7) begin
          state_d     = S_GAP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {shift_q[6:0], MISO};
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
`ifdef SPI_SEQ_AUTOREAD_EN
          // op rewritten to 11 here, so the chained read cannot chain again
          if (op_q == 2'b10) begin
            state_d = S_START;
            op_d    = 2'b11;
            data_d  = 8'h00;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE || state_d != state_q)
      cnt_d = 5'd0;
    else
      cnt_d = 5'(cnt_q + 5'd1);

    // outputs registered from next state so they line up with state_q
    word_d = {op_d, data_d};
    ss_n_d = (state_d == S_IDLE) || (state_d == S_GAP);
    mosi_d = 1'b0;
    if (state_d == S_CMD)
      mosi_d = op_d[1];
    else if (state_d == S_SHIFT)
      mosi_d = word_d[4'd9 - cnt_d[3:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      op_q        <= 2'b00;
      data_q      <= 8'h00;
      shift_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      shift_q     <= shift_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer (RD_LAT=2, GAP=1).
// Slave model drives MISO during the RX window of each SS_n-low frame.
module tb_spi_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] miso_byte = 8'h3C;
  int         lo = 0;

  logic       ss_tr  [64];
  logic       mosi_tr[64];
  logic       rv_tr  [64];
  logic [7:0] rd_tr  [64];
  logic       busy_tr[64];
  logic       rdy_tr [64];

  spi_txn_sequencer #(.RD_LAT(2), .GAP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  // RX occupies SS_n-low cycles 14..21 when RD_LAT=2
  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (lo >= 14 && lo < 22)
        MISO = miso_byte[7 - (lo - 14)];
      else
        MISO = 1'b0;
      lo++;
    end else begin
      lo   = 0;
      MISO = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      ss_tr[i]   = SS_n;
      mosi_tr[i] = MOSI;
      rv_tr[i]   = rsp_valid;
      rd_tr[i]   = rsp_data;
      busy_tr[i] = busy;
      rdy_tr[i]  = req_ready;
      @(negedge clk);
    end
  endtask

  function automatic int low_cnt(input int a, input int b);
    int c = 0;
    for (int i = a; i < b; i++) if (ss_tr[i] === 1'b0) c++;
    return c;
  endfunction

  function automatic int rv_cnt(input int a, input int b);
    int c = 0;
    for (int i = a; i < b; i++) if (rv_tr[i] !== 1'b0) c++;
    return c;
  endfunction

  function automatic logic [11:0] mosi12(input int s);
    logic [11:0] w = '0;
    for (int i = 0; i < 12; i++) w = {w[10:0], mosi_tr[s + i]};
    return w;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    check("ready_before_issue", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'b11;
    req_data  = 8'hEE;
  endtask

  initial begin
    int gap_busy;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_data  = 8'hFF;
    MISO      = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ss_n", SS_n, 1'b1);
      check("rst_mosi", MOSI, 1'b0);
      check("rst_ready", req_ready, 1'b0);
      check("rst_rv", rsp_valid, 1'b0);
    end
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rsp_data, 8'h00);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);

    issue(2'b00, 8'hA5);
    capture(16);
    check("wa_low", low_cnt(0, 16), 12);
    check("wa_mosi", mosi12(0), 12'h0A5);
    check("wa_gap_ss", ss_tr[12], 1'b1);
    check("wa_no_rv", rv_cnt(0, 16), 0);
    check("wa_idle_busy", busy_tr[13], 1'b0);
    check("wa_idle_ready", rdy_tr[13], 1'b1);

    miso_byte = 8'h3C;
    issue(2'b11, 8'h00);
    capture(26);
    check("rd_low", low_cnt(0, 26), 22);
    check("rd_cmd_bit", mosi_tr[1], 1'b1);
    check("rd_rv_cnt", rv_cnt(0, 26), 1);
    check("rd_rv_pos", rv_tr[22], 1'b1);
    check("rd_data", rd_tr[22], 8'h3C);
    check("rd_hold", rd_tr[25], 8'h3C);

    req_valid = 1'b1;
    req_op    = 2'b01;
    req_data  = 8'hFF;
    check("b2b_ready0", req_ready, 1'b1);
    @(negedge clk);
    req_op   = 2'b00;
    req_data = 8'h10;
    capture(27);
    req_valid = 1'b0;
    check("b2b_f1_mosi", mosi12(0), 12'h1FF);
    check("b2b_f1_low", low_cnt(0, 12), 12);
    gap_busy = 0;
    for (int i = 12; i < 14; i++)
      if (ss_tr[i] === 1'b1 && busy_tr[i] === 1'b1) gap_busy++;
    check("b2b_gap_cycles", gap_busy, 1);
    check("b2b_idle_ready", rdy_tr[13], 1'b1);
    check("b2b_f2_start", ss_tr[14], 1'b0);
    check("b2b_f2_mosi", mosi12(14), 12'h010);
    check("b2b_f2_low", low_cnt(14, 26), 12);
    check("b2b_f2_end", ss_tr[26], 1'b1);
    repeat (3) @(negedge clk);

    miso_byte = 8'hC3;
    issue(2'b11, 8'h00);
    repeat (7) @(negedge clk);
    check("mr_in_shift", SS_n, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_ss_n", SS_n, 1'b1);
    check("mr_busy", busy, 1'b0);
    check("mr_ready", req_ready, 1'b0);
    check("mr_rdata", rsp_data, 8'h00);
    rst_n = 1'b1;
    capture(20);
    check("mr_no_rv", rv_cnt(0, 20), 0);
    check("mr_stays_hi", low_cnt(0, 20), 0);
    issue(2'b00, 8'h5A);
    capture(16);
    check("mr_next_low", low_cnt(0, 16), 12);
    check("mr_next_mosi", mosi12(0), 12'h05A);

    miso_byte = 8'h96;
    issue(2'b10, 8'h07);
    capture(40);
    check("ar_f1_mosi", mosi12(0), 12'h607);
`ifdef SPI_SEQ_AUTOREAD_EN
    check("ar_low", low_cnt(0, 40), 34);
    check("ar_rv_cnt", rv_cnt(0, 40), 1);
    check("ar_busy_mid", busy_tr[13], 1'b1);
    check("ar_ready_mid", rdy_tr[13], 1'b0);
    check("ar_f2_cmd", mosi_tr[14], 1'b1);
    check("ar_data", rd_tr[35], 8'h96);
`else
    check("ar_low", low_cnt(0, 40), 12);
    check("ar_rv_cnt", rv_cnt(0, 40), 0);
    check("ar_busy_end", busy_tr[13], 1'b0);
    check("ar_ready_end", rdy_tr[13], 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
